// File: rtl/main_mem_ctrl.sv
// main_mem_ctrl: arbitrates a byte-wide main memory between an instruction-fetch port (0) and a
// load/store port (1). Each request moves one LINE_BYTES block as LINE_BYTES consecutive byte
// beats, each beat held MEM_LAT cycles on the memory pins.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   reqN_i / weN_i         request (held until ackN_o), 1 = write block / 0 = read block
//   addrN_i / wdataN_i     byte address (line-aligned internally), write block (little-endian)
//   ack0_o / ack1_o        one-cycle completion pulse for the granted port
//   rdata_o                last completed read block, held until the next read completes
//   busy_o                 transfer in progress
//   mem_cs_o/oe_o/we_o     memory strobes
//   mem_addr_o             memory byte address (holds last value when idle)
//   mem_data_io            memory data bus, driven only during write beats
module main_mem_ctrl #(
   parameter int unsigned LINE_BYTES = 4,
   parameter int unsigned MEM_LAT    = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req0_i,
   input  logic                    req1_i,
   input  logic                    we0_i,
   input  logic                    we1_i,
   input  logic [31:0]             addr0_i,
   input  logic [31:0]             addr1_i,
   input  logic [8*LINE_BYTES-1:0] wdata0_i,
   input  logic [8*LINE_BYTES-1:0] wdata1_i,
   output logic                    ack0_o,
   output logic                    ack1_o,
   output logic [8*LINE_BYTES-1:0] rdata_o,
   output logic                    busy_o,
   output logic                    mem_cs_o,
   output logic                    mem_oe_o,
   output logic                    mem_we_o,
   output logic [31:0]             mem_addr_o,
   inout  wire  [7:0]              mem_data_io
);

   localparam int unsigned BeatW = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
   localparam int unsigned LatW  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [BeatW-1:0] LastBeat = BeatW'(LINE_BYTES - 1);
   localparam logic [LatW-1:0]  LastLat  = LatW'(MEM_LAT - 1);
   localparam logic [31:0]      AddrMask = ~(32'(LINE_BYTES) - 32'd1);

   typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

   state_e                     state_q, state_d;
   logic [BeatW-1:0]           beat_q, beat_d;
   logic [LatW-1:0]            lat_q, lat_d;
   logic                       port_q, port_d;
   logic                       we_q, we_d;
   logic                       last_grant_q, last_grant_d;
   logic [31:0]                addr_q, addr_d;
   logic [LINE_BYTES-1:0][7:0] wdata_q, wdata_d;
   logic [LINE_BYTES-1:0][7:0] rbuf_q, rbuf_d;
   logic [LINE_BYTES-1:0][7:0] rdata_q, rdata_d;
   logic                       grant;
   logic                       beat_end;

   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      lat_d        = lat_q;
      port_d       = port_q;
      we_d         = we_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rbuf_d       = rbuf_q;
      rdata_d      = rdata_q;
      // On a tie the port not granted last wins; a lone requester always wins.
      grant        = (req0_i && req1_i) ? ~last_grant_q : req1_i;
      beat_end     = (lat_q == LastLat);

      unique case (state_q)
         StIdle: begin
            if (req0_i || req1_i) begin
               state_d      = StXfer;
               port_d       = grant;
               last_grant_d = grant;
               we_d         = grant ? we1_i : we0_i;
               addr_d       = (grant ? addr1_i : addr0_i) & AddrMask;
               wdata_d      = grant ? wdata1_i : wdata0_i;
               beat_d       = '0;
               lat_d        = '0;
            end
         end
         StXfer: begin
            if (!beat_end) begin
               lat_d = lat_q + LatW'(1);
            end else begin
               lat_d = '0;
               if (!we_q) rbuf_d[beat_q] = mem_data_io;
               if (beat_q == LastBeat) begin
                  state_d = StDone;
                  // rdata_o only changes when a whole read block has arrived.
                  if (!we_q) rdata_d = rbuf_d;
               end else begin
                  beat_d = beat_q + BeatW'(1);
                  addr_d = addr_q + 32'd1;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         beat_q       <= '0;
         lat_q        <= '0;
         port_q       <= 1'b0;
         we_q         <= 1'b0;
         last_grant_q <= 1'b1;
         addr_q       <= '0;
         wdata_q      <= '0;
         rbuf_q       <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         lat_q        <= lat_d;
         port_q       <= port_d;
         we_q         <= we_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rbuf_q       <= rbuf_d;
         rdata_q      <= rdata_d;
      end
   end

   assign busy_o      = (state_q != StIdle);
   assign ack0_o      = (state_q == StDone) && !port_q;
   assign ack1_o      = (state_q == StDone) && port_q;
   assign mem_cs_o    = (state_q == StXfer);
   assign mem_oe_o    = (state_q == StXfer) && !we_q;
   assign mem_we_o    = (state_q == StXfer) && we_q;
   assign mem_addr_o  = addr_q;
   assign rdata_o     = rdata_q;
   assign mem_data_io = mem_we_o ? wdata_q[beat_q] : 8'bz;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Bench for main_mem_ctrl (LINE_BYTES = 4, MEM_LAT = 2): directed scenarios plus randomized
// two-port traffic, checked every cycle against a timeline model of the transfer rules.
module tb_main_mem_ctrl;

   localparam int unsigned Lb  = 4;
   localparam int unsigned Lat = 2;
   localparam int unsigned Dur = Lb * Lat;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req0_i = 1'b0, req1_i = 1'b0, we0_i = 1'b0, we1_i = 1'b0;
   logic [31:0] addr0_i = '0, addr1_i = '0, wdata0_i = '0, wdata1_i = '0;
   logic        ack0_o, ack1_o, busy_o, mem_cs_o, mem_oe_o, mem_we_o;
   logic [31:0] rdata_o, mem_addr_o;
   wire  [7:0]  mem_data_io;

   int n_cmp = 0;
   int n_err = 0;

   main_mem_ctrl #(.LINE_BYTES(Lb), .MEM_LAT(Lat)) u_dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .req0_i     (req0_i),
      .req1_i     (req1_i),
      .we0_i      (we0_i),
      .we1_i      (we1_i),
      .addr0_i    (addr0_i),
      .addr1_i    (addr1_i),
      .wdata0_i   (wdata0_i),
      .wdata1_i   (wdata1_i),
      .ack0_o     (ack0_o),
      .ack1_o     (ack1_o),
      .rdata_o    (rdata_o),
      .busy_o     (busy_o),
      .mem_cs_o   (mem_cs_o),
      .mem_oe_o   (mem_oe_o),
      .mem_we_o   (mem_we_o),
      .mem_addr_o (mem_addr_o),
      .mem_data_io(mem_data_io)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         if (n_err <= 40) $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [7:0] dflt(input int i);
      return 8'(i) ^ 8'hA5;
   endfunction

   // Memory device: 256 bytes aliased on the low address byte.
   logic [7:0] tb_mem [256];
   bit         mem_ready = 1'b0;
   always @(posedge clk_i) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) tb_mem[i] <= dflt(i);
         mem_ready <= 1'b1;
      end else if (mem_cs_o && mem_we_o) begin
         tb_mem[mem_addr_o[7:0]] <= mem_data_io;
      end
   end
   assign mem_data_io = (mem_cs_o && mem_oe_o) ? tb_mem[mem_addr_o[7:0]] : 8'bz;

   // Reference model: one transfer at a time, described by its grant cycle.
   int          cyc = 0;
   bit          m_act = 1'b0;
   int          m_start = 0;
   int          m_free = 0;
   bit          m_port = 1'b0, m_we = 1'b0, m_last_grant = 1'b1;
   logic [31:0] m_base = '0, m_wdata = '0, m_last_addr = '0, m_rdata = '0;
   logic [7:0]  ref_mem [256];
   bit          ref_ready = 1'b0;
   bit          ack_seen0 = 1'b0, ack_seen1 = 1'b0;

   always @(negedge clk_i) begin
      int          off, k;
      logic        e_cs, e_oe, e_we, e_busy;
      logic [1:0]  e_ack;
      logic [31:0] e_addr;
      if (!ref_ready) begin
         for (int i = 0; i < 256; i++) ref_mem[i] = dflt(i);
         ref_ready = 1'b1;
      end
      e_cs = 0; e_oe = 0; e_we = 0; e_busy = 0; e_ack = 2'b00; e_addr = m_last_addr;
      if (m_act) begin
         off = cyc - m_start;
         if (off >= 1 && off <= int'(Dur)) begin
            k = (off - 1) / Lat;
            e_cs = 1; e_busy = 1; e_we = m_we; e_oe = !m_we;
            e_addr = m_base + 32'(k);
            m_last_addr = e_addr;
            if (m_we) begin
               ref_mem[e_addr[7:0]] = m_wdata[8*k +: 8];
               chk("wbyte", mem_data_io, m_wdata[8*k +: 8]);
            end
         end else if (off == int'(Dur) + 1) begin
            e_busy = 1;
            e_ack[m_port] = 1'b1;
            if (!m_we)
               for (int b = 0; b < int'(Lb); b++) m_rdata[8*b +: 8] = ref_mem[8'(int'(m_base[7:0]) + b)];
            m_act = 0;
         end
      end
      chk("cs", mem_cs_o, e_cs);
      chk("oe", mem_oe_o, e_oe);
      chk("we", mem_we_o, e_we);
      chk("busy", busy_o, e_busy);
      chk("ack0", ack0_o, e_ack[0]);
      chk("ack1", ack1_o, e_ack[1]);
      chk("addr", mem_addr_o, e_addr);
      chk("rdata", rdata_o, m_rdata);
      ack_seen0 = ack0_o;
      ack_seen1 = ack1_o;
      if (rst_i) begin
         m_act = 0; m_free = cyc + 1; m_last_grant = 1; m_last_addr = '0; m_rdata = '0;
      end else if (!m_act && cyc >= m_free && (req0_i || req1_i)) begin
         m_port       = (req0_i && req1_i) ? !m_last_grant : req1_i;
         m_last_grant = m_port;
         m_we         = m_port ? we1_i : we0_i;
         m_base       = (m_port ? addr1_i : addr0_i) & ~32'(Lb - 1);
         m_wdata      = m_port ? wdata1_i : wdata0_i;
         m_start      = cyc;
         m_free       = cyc + int'(Dur) + 2;
         m_act        = 1;
      end
      cyc++;
   end

   // Stimulus: per-port request queues; a request stays up until its ack has been seen.
   req_t q0[$];
   req_t q1[$];

   task automatic step();
      req_t r;
      @(posedge clk_i);
      #1;
      if (req0_i && ack_seen0) req0_i = 1'b0;
      if (req1_i && ack_seen1) req1_i = 1'b0;
      if (!req0_i && q0.size() != 0) begin
         r = q0.pop_front();
         req0_i = 1'b1; we0_i = r.we; addr0_i = r.addr; wdata0_i = r.wdata;
      end
      if (!req1_i && q1.size() != 0) begin
         r = q1.pop_front();
         req1_i = 1'b1; we1_i = r.we; addr1_i = r.addr; wdata1_i = r.wdata;
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || req0_i || req1_i || busy_o) && n < 300) begin
         step();
         n++;
      end
      chk("drain", n < 300, 1'b1);
   endtask

   function automatic req_t rand_req();
      req_t r;
      r.we    = 1'($urandom_range(0, 1));
      r.addr  = $urandom();
      r.wdata = $urandom();
      return r;
   endfunction

   initial begin
      repeat (3) step();
      rst_i = 1'b0;
      // Contention straight out of reset, both ports kept busy.
      for (int i = 0; i < 4; i++) begin
         q0.push_back(rand_req());
         q1.push_back(rand_req());
      end
      drain();
      // Write then read back through the other port with an unaligned address.
      q1.push_back('{we: 1'b1, addr: 32'h10, wdata: 32'h0403_0201});
      drain();
      q0.push_back('{we: 1'b0, addr: 32'h13, wdata: 32'h0});
      drain();
      chk("readback", rdata_o, 32'h0403_0201);
      // Read across the top of the address space.
      q0.push_back('{we: 1'b0, addr: 32'hFFFF_FFFC, wdata: 32'h0});
      drain();
      chk("wrap_addr", mem_addr_o, 32'hFFFF_FFFF);
      // Request withdrawn mid-transfer still completes.
      q0.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0});
      step();
      step();
      req0_i = 1'b0;
      addr0_i = $urandom();
      drain();
      // Reset during the last cycle of the second write beat.
      q1.push_back('{we: 1'b1, addr: 32'h10, wdata: 32'hDDCC_BBAA});
      step();
      repeat (2 * Lat) step();
      rst_i = 1'b1;
      req1_i = 1'b0;
      step();
      rst_i = 1'b0;
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_addr", mem_addr_o, 32'h0);
      chk("rst_rdata", rdata_o, 32'h0);
      q0.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0});
      drain();
      chk("partial", rdata_o, 32'h0403_BBAA);
      // Random traffic with occasional resets.
      for (int i = 0; i < 2500; i++) begin
         if (q0.size() == 0 && !req0_i && $urandom_range(0, 2) == 0) q0.push_back(rand_req());
         if (q1.size() == 0 && !req1_i && $urandom_range(0, 2) == 0) q1.push_back(rand_req());
         if ($urandom_range(0, 499) == 0) begin
            rst_i = 1'b1;
            req0_i = 1'b0;
            req1_i = 1'b0;
            step();
            rst_i = 1'b0;
         end else begin
            step();
         end
      end
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

endmodule
